// File: rtl/ccm_bank.sv
// ccm_bank: Timer_A capture/compare bank (CHANNELS channels) plus the TAxIV interrupt vector.
// Optional macro CCM_BANK_SHADOW_EN adds per-channel compare latches CLn loaded under CCTL bit9 (CLLD).
module ccm_bank #(
   parameter int          CHANNELS  = 3,
   parameter int          TAR_WIDTH = 16,
   parameter logic [15:0] BASE_CCTL = 16'h0342,
   parameter logic [15:0] BASE_CCR  = 16'h0352,
   parameter logic [15:0] IV_ADDR   = 16'h036E
) (
   input  logic                 MCLK,
   input  logic                 reset,
   input  logic                 TimerTick,
   input  logic [TAR_WIDTH-1:0] TAR,
   input  logic                 TAIFG,
   input  logic [15:0]          MAB,
   input  logic [15:0]          MDBwrite,
   input  logic                 MW,
   input  logic                 MR,
   input  logic                 BW,
   input  logic [CHANNELS-1:0]  CCIA,
   input  logic [CHANNELS-1:0]  CCIB,
   input  logic                 CCIFG0clr,
   output logic [CHANNELS-1:0]  OUT,
   output logic [CHANNELS-1:0]  EQU,
   output logic                 CCIFG0irq,
   output logic                 IVirq,
   output logic                 TAIFGclr,
   output logic [15:0]          MDBread
);

`ifdef CCM_BANK_SHADOW_EN
   localparam logic [15:0] WMASK = 16'hFBF7;
`else
   localparam logic [15:0] WMASK = 16'hF9F7;
`endif

   logic [15:0]          cctl_r [CHANNELS];
   logic [15:0]          cctl_n [CHANNELS];
   logic [TAR_WIDTH-1:0] ccr_r  [CHANNELS];
   logic [TAR_WIDTH-1:0] ccr_n  [CHANNELS];
`ifdef CCM_BANK_SHADOW_EN
   logic [TAR_WIDTH-1:0] cl_r   [CHANNELS];
   logic [TAR_WIDTH-1:0] cl_n   [CHANNELS];
`endif
   logic [CHANNELS-1:0]  cci_r, cci_d_r, scci_r, pend_r, out_r;
   logic [CHANNELS-1:0]  scci_n, pend_n, out_n;
   logic [CHANNELS-1:0]  sel_s, trig_s, capture_s, match_s, eqe_s, clr_s;
   logic [CHANNELS-1:0]  cctl_sel_s, ccr_sel_s;
   logic                 we_lo_s, we_hi_s, iv_sel_s, iv_rd_s, ivirq_s;
   logic                 taifgclr_r, taifgclr_n;
   logic [15:0]          wm_s, iv_val_s;
   logic [2:0]           iv_k_s;

   function automatic logic [15:0] merge16(input logic [15:0] old_v, input logic [15:0] new_v,
                                           input logic lo, input logic hi);
      return {hi ? new_v[15:8] : old_v[15:8], lo ? new_v[7:0] : old_v[7:0]};
   endfunction

   // Output unit: e is this channel's EQU event, z is EQU0; z takes precedence where both act.
   function automatic logic out_next(input logic [2:0] mode, input logic cur, input logic bit_v,
                                     input logic e, input logic z);
      logic r;
      case (mode)
         3'd0:    r = bit_v;
         3'd1:    r = e ? 1'b1 : cur;
         3'd2:    r = z ? 1'b0 : (e ? ~cur : cur);
         3'd3:    r = z ? 1'b0 : (e ? 1'b1 : cur);
         3'd4:    r = e ? ~cur : cur;
         3'd5:    r = e ? 1'b0 : cur;
         3'd6:    r = z ? 1'b1 : (e ? ~cur : cur);
         3'd7:    r = z ? 1'b1 : (e ? 1'b0 : cur);
         default: r = cur;
      endcase
      return r;
   endfunction

   // Address decode, compare events and IV priority encoding.
   always_comb begin
      we_lo_s    = ~BW | ~MAB[0];
      we_hi_s    = ~BW | MAB[0];
      wm_s       = {{8{we_hi_s}}, {8{we_lo_s}}} & WMASK;
      iv_sel_s   = (MAB[15:1] == IV_ADDR[15:1]);
      iv_k_s     = 3'd0;
      ivirq_s    = 1'b0;
      cctl_sel_s = {CHANNELS{1'b0}};
      ccr_sel_s  = {CHANNELS{1'b0}};
      match_s    = {CHANNELS{1'b0}};
      eqe_s      = {CHANNELS{1'b0}};
      clr_s      = {CHANNELS{1'b0}};
      for (int n = CHANNELS - 1; n >= 0; n--) begin
         cctl_sel_s[n] = (MAB[15:1] == BASE_CCTL[15:1] + 15'(n));
         ccr_sel_s[n]  = (MAB[15:1] == BASE_CCR[15:1] + 15'(n));
`ifdef CCM_BANK_SHADOW_EN
         match_s[n]    = (TAR == cl_r[n]);
`else
         match_s[n]    = (TAR == ccr_r[n]);
`endif
         eqe_s[n]      = TimerTick & match_s[n];
         iv_k_s        = ((n >= 1) && cctl_r[n][0] && cctl_r[n][4]) ? 3'(n) : iv_k_s;
         ivirq_s       = ivirq_s | ((n >= 1) && cctl_r[n][0] && cctl_r[n][4]);
      end
      iv_val_s   = (iv_k_s != 3'd0) ? {12'h000, iv_k_s, 1'b0} : (TAIFG ? 16'h000E : 16'h0000);
      iv_rd_s    = MR & ~BW & iv_sel_s;
      for (int n = 0; n < CHANNELS; n++) begin
         clr_s[n] = (n == 0) ? CCIFG0clr : (iv_rd_s & (iv_k_s == 3'(n)));
      end
      taifgclr_n = iv_rd_s & (iv_k_s == 3'd0) & TAIFG;
   end

   // Per-channel next state: input select, capture, flags, CCR writes and output unit.
   always_comb begin
      logic        wr_c;
      logic        hw_set;
      logic        ifg;
      logic [15:0] cctl_w;
      wr_c      = 1'b0;
      hw_set    = 1'b0;
      ifg       = 1'b0;
      cctl_w    = 16'h0000;
      cctl_n    = cctl_r;
      ccr_n     = ccr_r;
`ifdef CCM_BANK_SHADOW_EN
      cl_n      = cl_r;
`endif
      scci_n    = scci_r;
      pend_n    = pend_r;
      out_n     = out_r;
      sel_s     = {CHANNELS{1'b0}};
      trig_s    = {CHANNELS{1'b0}};
      capture_s = {CHANNELS{1'b0}};
      for (int n = 0; n < CHANNELS; n++) begin
         case (cctl_r[n][13:12])
            2'b00:   sel_s[n] = CCIA[n];
            2'b01:   sel_s[n] = CCIB[n];
            2'b10:   sel_s[n] = 1'b0;
            default: sel_s[n] = 1'b1;
         endcase
         case (cctl_r[n][15:14])
            2'b01:   trig_s[n] = cctl_r[n][8] & cci_r[n] & ~cci_d_r[n];
            2'b10:   trig_s[n] = cctl_r[n][8] & ~cci_r[n] & cci_d_r[n];
            2'b11:   trig_s[n] = cctl_r[n][8] & (cci_r[n] ^ cci_d_r[n]);
            default: trig_s[n] = 1'b0;
         endcase
         // SCS holds a qualified edge until the next timer tick.
         capture_s[n] = cctl_r[n][11] ? (TimerTick & (pend_r[n] | trig_s[n])) : trig_s[n];
         pend_n[n]    = cctl_r[n][8] & cctl_r[n][11] & ~TimerTick & (pend_r[n] | trig_s[n]);
         hw_set       = capture_s[n] | (~cctl_r[n][8] & eqe_s[n]);

         wr_c   = MW & cctl_sel_s[n];
         cctl_w = wr_c ? ((cctl_r[n] & ~wm_s) | (MDBwrite & wm_s)) : cctl_r[n];
         ifg    = hw_set ? 1'b1 : ((clr_s[n] & ~(wr_c & we_lo_s)) ? 1'b0 : cctl_w[0]);
         cctl_n[n] = {cctl_w[15:2], cctl_w[1] | (capture_s[n] & cctl_r[n][0]), ifg};

         ccr_n[n]  = capture_s[n] ? TAR :
                     ((MW & ccr_sel_s[n]) ? TAR_WIDTH'(merge16(16'(ccr_r[n]), MDBwrite, we_lo_s, we_hi_s))
                                          : ccr_r[n]);
         scci_n[n] = capture_s[n] ? cci_r[n] : scci_r[n];
         out_n[n]  = out_next(cctl_r[n][7:5], out_r[n], cctl_r[n][2], eqe_s[n], eqe_s[0]);
`ifdef CCM_BANK_SHADOW_EN
         cl_n[n]   = cctl_r[n][9] ? ((TimerTick & (TAR == {TAR_WIDTH{1'b0}})) ? ccr_r[n] : cl_r[n])
                                  : ccr_n[n];
`endif
      end
   end

   // Bus read mux; reflects register state ahead of the clock edge.
   always_comb begin
      MDBread = 16'h0000;
      for (int n = 0; n < CHANNELS; n++) begin
         if (cctl_sel_s[n]) begin
            MDBread = cctl_r[n] | {5'b00000, scci_r[n], 6'b000000, cci_r[n], 3'b000};
         end else if (ccr_sel_s[n]) begin
            MDBread = 16'(ccr_r[n]);
         end else begin
            MDBread = MDBread;
         end
      end
      MDBread = iv_sel_s ? iv_val_s : MDBread;
   end

   // Register update with synchronous reset.
   always_ff @(posedge MCLK) begin
      if (reset) begin
         for (int n = 0; n < CHANNELS; n++) begin
            cctl_r[n] <= 16'h0000;
            ccr_r[n]  <= {TAR_WIDTH{1'b0}};
`ifdef CCM_BANK_SHADOW_EN
            cl_r[n]   <= {TAR_WIDTH{1'b0}};
`endif
         end
         cci_r      <= {CHANNELS{1'b0}};
         cci_d_r    <= {CHANNELS{1'b0}};
         scci_r     <= {CHANNELS{1'b0}};
         pend_r     <= {CHANNELS{1'b0}};
         out_r      <= {CHANNELS{1'b0}};
         taifgclr_r <= 1'b0;
      end else begin
         cctl_r     <= cctl_n;
         ccr_r      <= ccr_n;
`ifdef CCM_BANK_SHADOW_EN
         cl_r       <= cl_n;
`endif
         cci_r      <= sel_s;
         cci_d_r    <= cci_r;
         scci_r     <= scci_n;
         pend_r     <= pend_n;
         out_r      <= out_n;
         taifgclr_r <= taifgclr_n;
      end
   end

   assign OUT       = out_r;
   assign EQU       = match_s;
   assign TAIFGclr  = taifgclr_r;
   assign CCIFG0irq = cctl_r[0][0] & cctl_r[0][4];
   assign IVirq     = ivirq_s;

endmodule

// File: tb/tb_ccm_bank.sv
// tb_ccm_bank: directed checks of ccm_bank with default parameters (3 channels, 16-bit timer).
module tb_ccm_bank;
   logic        MCLK = 1'b0;
   logic        reset = 1'b1;
   logic        TimerTick = 1'b0;
   logic [15:0] TAR = 16'h0000;
   logic        TAIFG = 1'b0;
   logic [15:0] MAB = 16'h0000;
   logic [15:0] MDBwrite = 16'h0000;
   logic        MW = 1'b0;
   logic        MR = 1'b0;
   logic        BW = 1'b0;
   logic [2:0]  CCIA = 3'b000;
   logic [2:0]  CCIB = 3'b000;
   logic        CCIFG0clr = 1'b0;
   logic [2:0]  OUT;
   logic [2:0]  EQU;
   logic        CCIFG0irq;
   logic        IVirq;
   logic        TAIFGclr;
   logic [15:0] MDBread;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] d;

   ccm_bank dut (
      .MCLK(MCLK), .reset(reset), .TimerTick(TimerTick), .TAR(TAR), .TAIFG(TAIFG),
      .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .MR(MR), .BW(BW),
      .CCIA(CCIA), .CCIB(CCIB), .CCIFG0clr(CCIFG0clr),
      .OUT(OUT), .EQU(EQU), .CCIFG0irq(CCIFG0irq), .IVirq(IVirq),
      .TAIFGclr(TAIFGclr), .MDBread(MDBread)
   );

   always #5 MCLK = ~MCLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge MCLK);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] v, input logic bw);
      MAB = a; MDBwrite = v; BW = bw; MW = 1'b1;
      cyc(1);
      MW = 1'b0; BW = 1'b0; MAB = 16'h0000;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] v);
      MAB = a; MR = 1'b1;
      #1;
      v = MDBread;
      cyc(1);
      MR = 1'b0; MAB = 16'h0000;
   endtask

   task automatic tstep(input logic [15:0] v);
      TAR = v; TimerTick = 1'b1;
      cyc(1);
      TimerTick = 1'b0;
      cyc(2);
   endtask

   initial begin
      cyc(2);
      reset = 1'b0;
      // Reset state
      rd(16'h0344, d); chk("rst_cctl1", d, 16'h0000);
      rd(16'h0354, d); chk("rst_ccr1", d, 16'h0000);
      chk("rst_out", 16'(OUT), 16'h0000);
      chk("rst_equ", 16'(EQU), 16'h0007);
      chk("rst_taifgclr", 16'(TAIFGclr), 16'h0000);
      chk("rst_ivirq", 16'(IVirq), 16'h0000);

      // Compare set/reset, OUTMOD 3 on channel 1
      wr(16'h0344, 16'h0070, 1'b0);
      wr(16'h0354, 16'h0020, 1'b0);
      wr(16'h0352, 16'h0040, 1'b0);
      rd(16'h0344, d); chk("cctl1_rb", d, 16'h0070);
      tstep(16'h001E);
      tstep(16'h001F);
      chk("out1_pre", 16'(OUT[1]), 16'h0000);
      TAR = 16'h0020; TimerTick = 1'b1;
      #1;
      chk("equ1_hit", 16'(EQU), 16'h0002);
      chk("out1_same", 16'(OUT[1]), 16'h0000);
      cyc(1);
      TimerTick = 1'b0;
      chk("out1_set", 16'(OUT[1]), 16'h0001);
      for (int t = 16'h21; t < 16'h40; t++) tstep(16'(t));
      chk("out1_hold", 16'(OUT[1]), 16'h0001);
      TAR = 16'h0040; TimerTick = 1'b1;
      cyc(1);
      TimerTick = 1'b0;
      chk("out1_reset", 16'(OUT[1]), 16'h0000);
      rd(16'h0344, d); chk("ccifg1_cmp", d, 16'h0071);
      rd(16'h0342, d); chk("ccifg0_cmp", d, 16'h0001);

      // IV priority and read-to-clear
      wr(16'h0344, 16'h0011, 1'b0);
      wr(16'h0346, 16'h0011, 1'b0);
      TAIFG = 1'b1;
      #1;
      chk("ivirq_on", 16'(IVirq), 16'h0001);
      rd(16'h036E, d); chk("iv_rd1", d, 16'h0002);
      rd(16'h036E, d); chk("iv_rd2", d, 16'h0004);
      chk("ivirq_off", 16'(IVirq), 16'h0000);
      chk("taifgclr_idle", 16'(TAIFGclr), 16'h0000);
      rd(16'h036E, d); chk("iv_rd3", d, 16'h000E);
      chk("taifgclr_pulse", 16'(TAIFGclr), 16'h0001);
      cyc(1);
      chk("taifgclr_drop", 16'(TAIFGclr), 16'h0000);
      TAIFG = 1'b0;
      rd(16'h036E, d); chk("iv_empty", d, 16'h0000);
      rd(16'h0344, d); chk("cctl1_cleared", d, 16'h0010);

      // Capture overflow on channel 2
      wr(16'h0346, 16'h4100, 1'b0);
      TAR = 16'h0010; CCIA[2] = 1'b1;
      cyc(3);
      rd(16'h0356, d); chk("cap2_first", d, 16'h0010);
      rd(16'h0346, d); chk("cctl2_first", d, 16'h4509);
      CCIA[2] = 1'b0;
      cyc(3);
      TAR = 16'h0018; CCIA[2] = 1'b1;
      cyc(3);
      rd(16'h0356, d); chk("cap2_second", d, 16'h0018);
      rd(16'h0346, d); chk("cctl2_cov", d, 16'h450B);

      // SCS capture waits for the timer tick
      wr(16'h0344, 16'hC900, 1'b0);
      TAR = 16'h0050; CCIA[1] = 1'b1;
      cyc(4);
      rd(16'h0354, d); chk("scs_hold_ccr", d, 16'h0020);
      rd(16'h0344, d); chk("scs_hold_cctl", d, 16'hC908);
      TAR = 16'h0051; TimerTick = 1'b1;
      cyc(1);
      TimerTick = 1'b0;
      rd(16'h0354, d); chk("scs_ccr", d, 16'h0051);
      rd(16'h0344, d); chk("scs_cctl", d, 16'hCD09);

      // Byte writes, then capture colliding with a CCR1 write
      wr(16'h0355, 16'hABAB, 1'b1);
      rd(16'h0354, d); chk("bw_high", d, 16'hAB51);
      wr(16'h0354, 16'hCDCD, 1'b1);
      rd(16'h0354, d); chk("bw_low", d, 16'hABCD);
      wr(16'h0344, 16'hC100, 1'b0);
      TAR = 16'h0066; CCIA[1] = 1'b0;
      cyc(1);
      wr(16'h0354, 16'h1234, 1'b0);
      rd(16'h0354, d); chk("cap_wins", d, 16'h0066);
      rd(16'h0344, d); chk("cap_wins_cctl", d, 16'hC101);

      // CCIFG0 acknowledge and set-wins collision
      wr(16'h0342, 16'h0011, 1'b0);
      chk("ccifg0irq_on", 16'(CCIFG0irq), 16'h0001);
      CCIFG0clr = 1'b1;
      cyc(1);
      CCIFG0clr = 1'b0;
      chk("ccifg0_ack", 16'(CCIFG0irq), 16'h0000);
      TAR = 16'h0040; TimerTick = 1'b1; CCIFG0clr = 1'b1;
      cyc(1);
      TimerTick = 1'b0; CCIFG0clr = 1'b0;
      chk("ccifg0_setwins", 16'(CCIFG0irq), 16'h0001);

`ifdef CCM_BANK_SHADOW_EN
      // Compare latch reloads only at the TAR=0 tick
      wr(16'h0344, 16'h0200, 1'b0);
      wr(16'h0354, 16'h0030, 1'b0);
      tstep(16'h0030);
      rd(16'h0344, d); chk("shadow_old_miss", d, 16'h0200);
      tstep(16'h0066);
      rd(16'h0344, d); chk("shadow_old_hit", d, 16'h0201);
      tstep(16'h0000);
      wr(16'h0344, 16'h0200, 1'b0);
      tstep(16'h0030);
      rd(16'h0344, d); chk("shadow_new_hit", d, 16'h0201);
`else
      // Without compare latches bit9 stays 0 and CCR1 is compared directly
      wr(16'h0344, 16'h0200, 1'b0);
      rd(16'h0344, d); chk("bit9_ignored", d, 16'h0000);
      wr(16'h0354, 16'h0030, 1'b0);
      tstep(16'h0030);
      rd(16'h0344, d); chk("direct_cmp", d, 16'h0001);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
